fa: RTL and testbench
=====================

FA -- requirements
Module: fa

Interface
REQ-001 Parameter LATENCY, default 1, meaning number of register stages from inputs to sum/cout; legal range 1..4.
REQ-002 Parameter CNT_W, default 8, meaning width of the carry-event counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  qualifies a, b, cin in the current cycle.
REQ-006 a  input  1  addend bit.
REQ-007 b  input  1  addend bit.
REQ-008 cin  input  1  carry-in bit.
REQ-009 sum  output  1  registered sum bit, a XOR b XOR cin.
REQ-010 cout  output  1  registered carry-out, majority(a, b, cin).
REQ-011 out_valid  output  1  marks the cycle in which sum/cout carry a valid result.
REQ-012 carry_cnt  output  CNT_W  number of valid results with cout=1 since reset, saturating.

Function
REQ-013 The arithmetic SHALL be the 1-bit full-adder truth table: {cout,sum} = a + b + cin, 2-bit result.
REQ-014 An input sampled with in_valid=1 on edge N SHALL appear on sum/cout with out_valid=1 after edge N+LATENCY-1, i.e. visible LATENCY cycles after presentation.
REQ-015 The pipeline SHALL carry in_valid alongside the data; each stage advances every cycle, with no stall or back-pressure.
REQ-016 When in_valid=0, a zero SHALL be shifted into the valid pipeline; sum/cout SHALL still update from the data pipeline (don't-care content) and consumers SHALL use out_valid only.
REQ-017 Back-to-back valid inputs SHALL produce back-to-back valid outputs, one per cycle, in order.
REQ-018 carry_cnt SHALL increment by 1 on each edge where the final stage holds out_valid=1 and cout=1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and hold that value until reset.
REQ-020 X on a/b/cin with in_valid=0 SHALL NOT propagate into out_valid or carry_cnt.
REQ-021 LATENCY outside 1..4 SHALL be a synthesis/elaboration error.

Reset
REQ-022 While rst=1 at a rising edge, all pipeline stages SHALL clear: sum=0, cout=0, out_valid=0, carry_cnt=0.
REQ-023 Reset SHALL take priority over in_valid; inputs presented in a reset cycle SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL flush all in-flight results; none SHALL emerge after reset deasserts.
REQ-025 The first input accepted after reset SHALL be the one presented on the first edge with rst=0.

Verification
REQ-026 LATENCY=1, rst pulse then a=0,b=1,cin=1,in_valid=1 -> next cycle sum=0, cout=1, out_valid=1, carry_cnt increments to 1.
REQ-027 Sequence (1,0,1) then (1,1,1) back-to-back -> sum/cout = 0/1 then 1/1 on consecutive cycles, carry_cnt +2.
REQ-028 Exhaustive 8 input combinations, each LATENCY in {1,2,4} -> every result matches a+b+cin, exactly LATENCY cycles late.
REQ-029 in_valid toggled 1,0,1 with (0,0,0),(1,1,1),(1,1,0) -> out_valid pattern 1,0,1, carry_cnt counts only the valid (1,1,0) carry.
REQ-030 CNT_W=2, five valid (1,1,1) inputs -> carry_cnt reaches 3 and holds at 3.
REQ-031 LATENCY=3, rst asserted one cycle after a valid input -> out_valid stays 0, carry_cnt=0 after reset.

Source files
------------

// File: rtl/fa.sv
// 1-bit full adder with a configurable register pipeline (LATENCY stages),
// a valid bit travelling alongside the data, and a saturating counter of
// valid results that produced a carry-out.
module fa #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             cout,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    // Reject unsupported pipeline depths at elaboration time.
    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("fa: LATENCY must be in 1..4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit i of each vector is pipeline stage i; stage LATENCY-1 drives the outputs.
    logic [LATENCY-1:0] sum_q, sum_d;
    logic [LATENCY-1:0] cout_q, cout_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Fresh result enters at the bottom of each chain; the chain is one
    // wider than the pipeline so the shift works for LATENCY=1 as well.
    logic               sum_in, cout_in;
    logic [LATENCY:0]   sum_chain, cout_chain, vld_chain;

    // Full-adder arithmetic and one-stage shift of every pipeline lane.
    always_comb begin
        sum_in     = a ^ b ^ cin;
        cout_in    = (a & b) | (a & cin) | (b & cin);
        sum_chain  = {sum_q, sum_in};
        cout_chain = {cout_q, cout_in};
        // Only the valid lane is forced clean; data lanes may carry junk
        // when in_valid is low and consumers must look at out_valid.
        vld_chain  = {vld_q, in_valid};
        sum_d      = sum_chain[LATENCY-1:0];
        cout_d     = cout_chain[LATENCY-1:0];
        vld_d      = vld_chain[LATENCY-1:0];
    end

    // Count valid carry-producing results at the output stage, sticking at full scale.
    always_comb begin
        cnt_d = cnt_q;
        if (vld_q[LATENCY-1] && cout_q[LATENCY-1] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State update; reset flushes every stage so no in-flight result survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sum       = sum_q[LATENCY-1];
    assign cout      = cout_q[LATENCY-1];
    assign out_valid = vld_q[LATENCY-1];
    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_fa.sv
// Bench for fa: five instances (LATENCY 1..4 with an 8-bit counter, plus
// LATENCY 1 with a 2-bit counter) share one randomized stimulus stream and
// are checked every cycle against a history-based model, with a few
// directed sequences pinned by literal expectations.
module tb_fa;

    logic clk;
    logic rst;
    logic in_valid;
    logic a, b, cin;

    logic [4:0] o_s, o_c, o_v;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
    logic [1:0] cnt4;

    int checks   = 0;
    int failures = 0;

    // Per-instance configuration.
    int lat_tab  [5] = '{1, 2, 3, 4, 1};
    int cmax_tab [5] = '{255, 255, 255, 255, 3};
    int mcnt     [5] = '{0, 0, 0, 0, 0};

    // Input history, indexed by rising-edge number.
    localparam int HMAX = 4096;
    logic h_rst [HMAX];
    logic h_v   [HMAX];
    logic h_s   [HMAX];
    logic h_c   [HMAX];
    int   n = 0;

    fa #(.LATENCY(1), .CNT_W(8)) u_l1 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .sum(o_s[0]), .cout(o_c[0]), .out_valid(o_v[0]), .carry_cnt(cnt0));
    fa #(.LATENCY(2), .CNT_W(8)) u_l2 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .sum(o_s[1]), .cout(o_c[1]), .out_valid(o_v[1]), .carry_cnt(cnt1));
    fa #(.LATENCY(3), .CNT_W(8)) u_l3 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .sum(o_s[2]), .cout(o_c[2]), .out_valid(o_v[2]), .carry_cnt(cnt2));
    fa #(.LATENCY(4), .CNT_W(8)) u_l4 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .sum(o_s[3]), .cout(o_c[3]), .out_valid(o_v[3]), .carry_cnt(cnt3));
    fa #(.LATENCY(1), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .sum(o_s[4]), .cout(o_c[4]), .out_valid(o_v[4]), .carry_cnt(cnt4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cnt_of(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            3: return int'(cnt3);
            default: return int'(cnt4);
        endcase
    endfunction

    task automatic chk(input string nm, input int inst, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t actual=%0d required=%0d", nm, inst, $time, act, req);
        end
    endtask

    // What the output stage must hold just after edge k for a pipeline of depth L:
    // the input of edge k-L+1, unless a reset landed anywhere in between.
    task automatic exp_at(input int L, input int k, output logic flushed,
                          output logic v, output logic s, output logic c);
        int e;
        e = k - L + 1;
        flushed = (e < 0);
        for (int j = (e < 0 ? 0 : e); j <= k; j++) begin
            if (h_rst[j]) flushed = 1'b1;
        end
        if (flushed) begin
            v = 1'b0; s = 1'b0; c = 1'b0;
        end else begin
            v = h_v[e]; s = h_s[e]; c = h_c[e];
        end
    endtask

    // Apply one cycle of inputs and log what the DUTs sample on this edge.
    task automatic step(input logic r, input logic v, input logic ia, input logic ib, input logic ic);
        int tot;
        rst = r; in_valid = v; a = ia; b = ib; cin = ic;
        @(posedge clk);
        tot = int'(ia) + int'(ib) + int'(ic);
        h_s[n]   = tot[0];
        h_c[n]   = tot[1];
        h_rst[n] = r;
        h_v[n]   = v;
        n++;
        @(negedge clk);
    endtask

    // Compare process: every cycle, every instance, against the history model.
    initial begin
        int   k;
        logic fl, ev, es, ec, pfl, pv, ps, pc;
        forever begin
            @(negedge clk);
            if (n > 0) begin
                k = n - 1;
                for (int i = 0; i < 5; i++) begin
                    exp_at(lat_tab[i], k, fl, ev, es, ec);
                    pv = 1'b0; pc = 1'b0;
                    if (k > 0) exp_at(lat_tab[i], k - 1, pfl, pv, ps, pc);
                    if (h_rst[k]) mcnt[i] = 0;
                    else if (pv && pc && mcnt[i] < cmax_tab[i]) mcnt[i] = mcnt[i] + 1;
                    chk("out_valid", i, int'(o_v[i]), int'(ev));
                    if (ev || fl) begin
                        chk("sum", i, int'(o_s[i]), int'(es));
                        chk("cout", i, int'(o_c[i]), int'(ec));
                    end
                    chk("carry_cnt", i, cnt_of(i), mcnt[i]);
                end
            end
        end
    end

    // Stimulus with a few literal expectations pinned on specific cycles.
    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;

        repeat (3) step(1, 0, 1, 1, 1);
        chk("lit_rst_vld", 0, int'(o_v[0]), 0);
        chk("lit_rst_sum", 0, int'(o_s[0]), 0);
        chk("lit_rst_cout", 0, int'(o_c[0]), 0);
        chk("lit_rst_cnt", 0, cnt_of(0), 0);

        // 0+1+1 -> sum 0, carry 1, one cycle later; counter follows an edge after.
        step(0, 1, 0, 1, 1);
        chk("lit011_sum", 0, int'(o_s[0]), 0);
        chk("lit011_cout", 0, int'(o_c[0]), 1);
        chk("lit011_vld", 0, int'(o_v[0]), 1);
        step(0, 0, 0, 0, 0);
        chk("lit011_cnt", 0, cnt_of(0), 1);

        // Back-to-back (1,0,1) then (1,1,1).
        step(0, 1, 1, 0, 1);
        chk("lit101_sum", 0, int'(o_s[0]), 0);
        chk("lit101_cout", 0, int'(o_c[0]), 1);
        step(0, 1, 1, 1, 1);
        chk("lit111_sum", 0, int'(o_s[0]), 1);
        chk("lit111_cout", 0, int'(o_c[0]), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_b2b_cnt", 0, cnt_of(0), 3);

        // Exhaustive combinations, back-to-back, across every latency.
        for (int j = 0; j < 8; j++) begin
            logic [2:0] bits;
            bits = 3'(j);
            step(0, 1, bits[2], bits[1], bits[0]);
        end
        repeat (5) step(0, 0, 0, 0, 0);

        // in_valid 1,0,1 with (0,0,0),(1,1,1),(1,1,0).
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("lit_tog_v1", 0, int'(o_v[0]), 1);
        step(0, 0, 1, 1, 1);
        chk("lit_tog_v2", 0, int'(o_v[0]), 0);
        step(0, 1, 1, 1, 0);
        chk("lit_tog_v3", 0, int'(o_v[0]), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_tog_cnt", 0, cnt_of(0), 1);

        // Saturation of the 2-bit counter.
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 1, 1, 1, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("lit_sat_cnt", 4, cnt_of(4), 3);
        chk("lit_nosat_cnt", 0, cnt_of(0), 5);

        // Reset one cycle after a valid input on the 3-deep pipeline.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 0, 0);
            chk("lit_flush_vld", 2, int'(o_v[2]), 0);
        end
        chk("lit_flush_cnt", 2, cnt_of(2), 0);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 3000; j++) begin
            logic r, v;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 9) < 7);
            step(r, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (6) step(0, 0, 0, 0, 0);

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
